player_motion: RTL

PLAYER_MOTION -- requirements
Module: player_motion

---
 rtl/player_motion.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/player_motion.sv
// player_motion: per-frame sprite physics for a platform jumper.
// Handles spawn, gravity, platform bounces, screen wrap and game over.
module player_motion #(
    parameter int NUM_PLAT = 3,
    parameter int X_START  = 280,
    parameter int Y_START  = 460,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int SIZE_X   = 8,
    parameter int SIZE_Y   = 10,
    parameter int X_STEP   = 1,
    parameter int JUMP_V   = 3,
    parameter int GRAV_DIV = 8,
    parameter int MAX_FALL = 4,
    parameter int TOL      = 5,
    parameter int WRAP_X   = 1
) (
    input  logic                    frame_clk,
    input  logic                    Reset,
    input  logic [7:0]              keycode,
    input  logic [10*NUM_PLAT-1:0]  plat_x,
    input  logic [10*NUM_PLAT-1:0]  plat_y,
    input  logic [10*NUM_PLAT-1:0]  plat_w,
    output logic [9:0]              pos_x,
    output logic [9:0]              pos_y,
    output logic [9:0]              vel_y,
    output logic [1:0]              state,
    output logic                    bounce,
    output logic [((NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1)-1:0] bounce_idx,
    output logic [7:0]              bounce_cnt,
    output logic                    gg
);

    localparam int IW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
    localparam int CW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

    localparam logic [9:0]         X_INIT  = 10'(X_START);
    localparam logic [9:0]         Y_INIT  = 10'(Y_START);
    localparam logic signed [11:0] HALF_X  = 12'(SIZE_X / 2);
    localparam logic signed [11:0] SZ_X    = 12'(SIZE_X);
    localparam logic signed [11:0] SZ_Y    = 12'(SIZE_Y);
    localparam logic signed [11:0] FLOOR   = 12'(Y_MAX);
    localparam logic signed [11:0] X_RIGHT = 12'(X_MAX + 1 - SIZE_X);
    localparam logic signed [11:0] X_EDGE  = 12'(X_MAX + 1);
    localparam logic signed [11:0] STEP    = 12'(X_STEP);
    localparam logic signed [11:0] JUMP    = 12'(JUMP_V);
    localparam logic signed [11:0] FALL    = 12'(MAX_FALL);
    localparam logic signed [11:0] WIN     = 12'(TOL);
    localparam logic [CW-1:0]      CNT_TOP = CW'(GRAV_DIV - 1);

    typedef enum logic [1:0] {
        READY = 2'd0,
        RUN   = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t        st;
    logic [CW-1:0] grav_cnt;

    logic                key_l, key_r, key_j;
    logic signed [11:0]  px, py, vy;
    logic signed [11:0]  vel_x, cx, foot;
    logic signed [11:0]  plx, ply, plw;
    logic signed [11:0]  vy_n, y_sum, y_n, x_sum, x_n;
    logic [CW-1:0]       cnt_n;
    logic                cnt_wrap, land, floor_hit;
    logic [IW-1:0]       land_idx;
    logic                unused_hi;

    assign key_l = (keycode == 8'd4);
    assign key_r = (keycode == 8'd7);
    assign key_j = (keycode == 8'd44);

    assign px = $signed({2'b00, pos_x});
    assign py = $signed({2'b00, pos_y});
    assign vy = $signed({{2{vel_y[9]}}, vel_y});

    assign state     = st;
    assign unused_hi = ^{x_n[11:10], y_n[11:10], vy_n[11:10]};

    // Next-frame velocity and position, landing search over all platforms
    always_comb begin
        vel_x = '0;
        if (key_l) begin
            vel_x = -STEP;
        end else if (key_r) begin
            vel_x = STEP;
        end

        cx   = px + HALF_X;
        foot = py + SZ_Y;

        // Scan high-to-low so the lowest qualifying index wins
        land     = 1'b0;
        land_idx = '0;
        plx      = '0;
        ply      = '0;
        plw      = '0;
        for (int i = NUM_PLAT - 1; i >= 0; i--) begin
            plx = $signed({2'b00, plat_x[10*i +: 10]});
            ply = $signed({2'b00, plat_y[10*i +: 10]});
            plw = $signed({2'b00, plat_w[10*i +: 10]});
            if (vy > 12'sd0 &&
                cx >= plx && cx <= plx + plw &&
                foot >= ply - WIN && foot < ply + WIN) begin
                land     = 1'b1;
                land_idx = IW'(i);
            end
        end

        cnt_wrap = (grav_cnt == CNT_TOP);
        cnt_n    = cnt_wrap ? '0 : grav_cnt + 1'b1;

        vy_n = vy;
        if (cnt_wrap && vy < FALL) begin
            vy_n = vy + 12'sd1;
        end
        if (land) begin
            vy_n  = -JUMP;
            cnt_n = '0;
        end

        y_sum = py + vy_n;
        y_n   = y_sum;
        if (y_sum < 12'sd0) begin
            y_n  = '0;
            vy_n = '0;
        end

        x_sum = px + vel_x;
        x_n   = x_sum;
        if (WRAP_X != 0) begin
            if (x_sum < 12'sd0) begin
                x_n = X_RIGHT;
            end else if (x_sum + SZ_X > X_EDGE) begin
                x_n = '0;
            end
        end else begin
            if (x_sum < 12'sd0) begin
                x_n = '0;
            end else if (x_sum > X_RIGHT) begin
                x_n = X_RIGHT;
            end
        end

        floor_hit = (foot >= FLOOR);
    end

    // Frame-rate game FSM: spawn, run physics, game over, restart
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            st         <= READY;
            pos_x      <= X_INIT;
            pos_y      <= Y_INIT;
            vel_y      <= '0;
            grav_cnt   <= '0;
            bounce     <= 1'b0;
            bounce_idx <= '0;
            bounce_cnt <= '0;
            gg         <= 1'b0;
        end else begin
            unique case (st)
                READY: begin
                    pos_x    <= X_INIT;
                    pos_y    <= Y_INIT;
                    vel_y    <= '0;
                    grav_cnt <= '0;
                    bounce   <= 1'b0;
                    gg       <= 1'b0;
                    if (key_l || key_r || key_j) begin
                        st <= RUN;
                    end
                end
                RUN: begin
                    bounce <= 1'b0;
                    if (floor_hit) begin
                        st <= OVER;
                        gg <= 1'b1;
                    end else begin
                        pos_x    <= x_n[9:0];
                        pos_y    <= y_n[9:0];
                        vel_y    <= vy_n[9:0];
                        grav_cnt <= cnt_n;
                        if (land) begin
                            bounce     <= 1'b1;
                            bounce_idx <= land_idx;
                            if (bounce_cnt != 8'hFF) begin
                                bounce_cnt <= bounce_cnt + 8'd1;
                            end
                        end
                    end
                end
                OVER: begin
                    vel_y  <= '0;
                    bounce <= 1'b0;
                    gg     <= 1'b1;
                    if (key_j) begin
                        st         <= READY;
                        pos_x      <= X_INIT;
                        pos_y      <= Y_INIT;
                        grav_cnt   <= '0;
                        bounce_idx <= '0;
                        bounce_cnt <= '0;
                        gg         <= 1'b0;
                    end
                end
                default: begin
                    st <= READY;
                end
            endcase
        end
    end

endmodule
